wb_arbiter: RTL and testbench

Write-back port scheduler for the 16-bit MIPS pipeline. It shares the single register-file write port between the in-order pipeline result (ALU/DM path, cannot stall at WB) and the multi-cycle multiply/divide unit (MDU). The ALU path has fixed priority. MDU results are queued in a small FIFO and drained into idle slots. A starvation FSM stalls the pipeline when MDU results back up.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 76 +++++++
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back port arbiter.
// Optional MDU bypass is controlled by the WB_MDU_BYPASS_EN macro (see wb_arbiter).
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 3;

    // r0 is hard-wired to zero, so writes to it never reach the register file
    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [0:0] {
        WB_NORMAL = 1'b0,
        WB_STALL  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU results; exposes per-entry rd for hazard lookup.
module wb_fifo
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic [ADDR_W-1:0]                push_rd,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output logic [ADDR_W-1:0]                head_rd,
    output logic [DATA_W-1:0]                head_data,
    output logic [DEPTH-1:0]                 ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]     ent_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]                 wr_ptr;
    logic [PTR_W:0]                 rd_ptr;
    logic [PTR_W:0]                 count;
    logic [DEPTH-1:0][ADDR_W-1:0]   mem_rd;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_data;
    logic                           do_push;
    logic                           do_pop;

    // The extra pointer MSB tells a full ring apart from an empty one
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_rd[wr_ptr[PTR_W-1:0]]   <= push_rd;
            mem_data[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    assign head_rd   = mem_rd[rd_ptr[PTR_W-1:0]];
    assign head_data = mem_data[rd_ptr[PTR_W-1:0]];
    assign ent_rd    = mem_rd;

    // A slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] offset;
        ent_valid = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = PTR_W'(i) - rd_ptr[PTR_W-1:0];
            ent_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port scheduler: ALU path has priority, MDU results queue and drain.
// Define WB_MDU_BYPASS_EN to send MDU results straight to the port when it is idle.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pipe_stall,
    input  logic [ADDR_W-1:0] hz_rd,
    output logic              hz_hit
);

    localparam logic [0:0] ST_NORMAL = WB_NORMAL;
    localparam logic [0:0] ST_STALL  = WB_STALL;
    localparam int         CNT_W     = $clog2(STARVE_MAX + 1);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         bypass;
    logic                         blocked;
    logic [ADDR_W-1:0]            head_rd;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic                         sel_valid;
    logic [ADDR_W-1:0]            sel_rd;
    logic [DATA_W-1:0]            sel_data;
    logic [0:0]                   state;
    logic [CNT_W-1:0]             starve_cnt;

    assign mdu_ready = !fifo_full;

`ifdef WB_MDU_BYPASS_EN
    assign bypass = mdu_valid && fifo_empty && !alu_valid;
`else
    assign bypass = 1'b0;
`endif

    // A full FIFO refuses the push even while popping; the freed slot opens next cycle
    assign fifo_push = mdu_valid && !fifo_full && !bypass;
    assign fifo_pop  = !alu_valid && !fifo_empty;
    assign blocked   = alu_valid && !fifo_empty;

    wb_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_rd   (mdu_rd),
        .push_data (mdu_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rd   (head_rd),
        .head_data (head_data),
        .ent_valid (ent_valid),
        .ent_rd    (ent_rd)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = head_rd;
            sel_data  = head_data;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = mdu_rd;
            sel_data  = mdu_data;
        end
    end

    // Port registers: r0 targets still consume the slot but never assert the enable
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= sel_valid && (sel_rd != ADDR_W'(REG_ZERO));
            if (sel_valid) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (blocked) begin
                        if (starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
                            state      <= ST_STALL;
                            pipe_stall <= 1'b1;
                        end else begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    // Stay stalled until a cycle begins with the FIFO already empty
                    if (fifo_empty) begin
                        state      <= ST_NORMAL;
                        starve_cnt <= '0;
                        pipe_stall <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == hz_rd)) begin
                hz_hit = 1'b1;
            end
        end
        if (hz_rd == ADDR_W'(REG_ZERO)) begin
            hz_hit = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based reference model.
`timescale 1ns/1ps
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 3;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
`ifdef WB_MDU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              pipe_stall;
    logic [ADDR_W-1:0] hz_rd;
    logic              hz_hit;

    wb_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall),
        .hz_rd      (hz_rd),
        .hz_hit     (hz_hit)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    wb_req_t q[$];
    bit      m_stall = 1'b0;
    int      run = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1; alu_valid = 1'b0; mdu_valid = 1'b1; mdu_rd = 3'd5; hz_rd = 3'd5;
        repeat (n) @(posedge clk);
        #1;
        q.delete(); m_stall = 1'b0; run = 0;
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_waddr", rf_waddr, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        check_eq("rst_stall", pipe_stall, 0);
        check_eq("rst_ready", mdu_ready, 1);
        check_eq("rst_hz", hz_hit, 0);
        reset = 1'b0; mdu_valid = 1'b0;
    endtask

    // One clock: drive inputs, check combinational outputs, advance model, check port registers
    task automatic cycle(input int av, input int ard, input int ad,
                         input int mv, input int mrd, input int md, input int hz);
        bit      ready_e, hit_e, wr, took;
        wb_req_t w;
        int      pre_n;
        @(negedge clk);
        alu_valid = av[0]; alu_rd = ard[2:0]; alu_data = ad[15:0];
        mdu_valid = mv[0]; mdu_rd = mrd[2:0]; mdu_data = md[15:0]; hz_rd = hz[2:0];
        #1;
        pre_n   = q.size();
        ready_e = (pre_n < DEPTH);
        hit_e   = 1'b0;
        foreach (q[i]) if (hz_rd != REG_ZERO && q[i].rd == hz_rd) hit_e = 1'b1;
        check_eq("mdu_ready", mdu_ready, ready_e);
        check_eq("hz_hit", hz_hit, hit_e);
        wr = 1'b0; took = 1'b0; w = '0;
        if (alu_valid) begin
            wr = 1'b1; w = '{rd: alu_rd, data: alu_data};
        end else if (pre_n > 0) begin
            wr = 1'b1; w = q.pop_front();
        end else if (BYP && mdu_valid) begin
            wr = 1'b1; took = 1'b1; w = '{rd: mdu_rd, data: mdu_data};
        end
        if (mdu_valid && ready_e && !took) q.push_back('{rd: mdu_rd, data: mdu_data});
        if (!m_stall) begin
            if (pre_n > 0 && alu_valid) begin
                run++;
                if (run >= STARVE_MAX) m_stall = 1'b1;
            end else begin
                run = 0;
            end
        end else if (pre_n == 0) begin
            m_stall = 1'b0; run = 0;
        end
        @(posedge clk);
        #1;
        check_eq("rf_we", rf_we, wr && (w.rd != REG_ZERO));
        if (wr && w.rd != REG_ZERO) begin
            check_eq("rf_waddr", rf_waddr, w.rd);
            check_eq("rf_wdata", rf_wdata, w.data);
        end
        check_eq("pipe_stall", pipe_stall, m_stall);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0; hz_rd = '0;
        do_reset(2);

        // ALU path, 1-cycle latency, r0 dropped
        cycle(1, 3, 'h1234, 0, 0, 0, 0);
        check_eq("alu_wdata", rf_wdata, 'h1234);
        cycle(1, 0, 'h5555, 0, 0, 0, 0);
        check_eq("alu_r0_we", rf_we, 0);

        // MDU into idle port
        cycle(0, 0, 0, 1, 5, 'hBEEF, 0);
        check_eq("mdu_lat1", rf_we, BYP);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("mdu_lat2", rf_we, !BYP);
        check_eq("mdu_addr", rf_waddr, 5);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Contention, starvation and drain with held third offer
        cycle(1, 1, 'h1111, 1, 2, 'hA002, 0);
        cycle(1, 2, 'h2222, 1, 4, 'hA004, 4);
        check_eq("full_ready", mdu_ready, 0);
        check_eq("hz_queued", hz_hit, 1);
        cycle(1, 3, 'h3333, 1, 6, 'hA006, 4);
        cycle(1, 4, 'h4444, 1, 6, 'hA006, 6);
        check_eq("no_stall_yet", pipe_stall, 0);
        cycle(1, 5, 'h5555, 1, 6, 'hA006, 6);
        check_eq("stall_set", pipe_stall, 1);
        cycle(0, 0, 0, 1, 6, 'hA006, 6);
        check_eq("drain1", rf_waddr, 2);
        cycle(0, 0, 0, 1, 6, 'hA006, 6);
        check_eq("drain2", rf_waddr, 4);
        cycle(0, 0, 0, 0, 0, 0, 6);
        check_eq("drain3", rf_wdata, 'hA006);
        check_eq("stall_hold", pipe_stall, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_eq("stall_clear", pipe_stall, 0);

        // Reset with a full queue discards it
        cycle(1, 1, 'h0101, 1, 3, 'hC003, 0);
        cycle(1, 2, 'h0202, 1, 7, 'hC007, 0);
        do_reset(1);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 3);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1 + $urandom_range(0, 1));
            end else begin
                int av;
                av = m_stall ? int'($urandom_range(0, 9) == 0) : int'($urandom_range(0, 3) != 0);
                cycle(av, $urandom_range(0, 7), $urandom_range(0, 65535),
                      $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 65535),
                      $urandom_range(0, 7));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
